// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: walks one shared external full adder across a WIDTH-bit add,
// one bit per clock LSB first, and publishes SUM/COUT with a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_d,
  input  logic             fa_s,
  input  logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        busy = 1'b1;
        fa_a = a_sh[0];
        fa_b = b_sh[0];
        fa_d = carry;
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SUM/COUT are written only on the final bit so readers never see a partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      SUM    <= '0;
      COUT   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= CIN;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        StRun: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_c;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            SUM  <= {fa_s, sum_sh[WIDTH-1:1]};
            COUT <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
